gfx256_fragment: RTL and testbench

- Fragment stage directly downstream of the clip/scissor stage. Accepts one clipped pixel at a time and takes its colour either from the flat/interpolated colour or from a texel fetched through the wishbone master reader.
- Applies colour-key discard and texel-alpha modulation, then hands the pixel to the blender. It uses the same pulse write/ack handshake on both sides.

---
 rtl/gfx256_fragment.sv | 162 ++++++++++++++++
 tb/tb_gfx256_fragment.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx256_fragment.sv
// Fragment stage: picks flat colour or a texel fetched over the wishbone reader,
// applies colour-key discard and texel-alpha modulation, then hands the pixel to the blender.
module gfx256_fragment #(
    parameter int point_width = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   texture_enable_i,
    input  logic                   colorkey_enable_i,
    input  logic [31:0]            colorkey_i,
    input  logic [1:0]             color_depth_i,
    input  logic [31:0]            tex0_base_i,
    input  logic [point_width-1:0] tex0_size_x_i,
    input  logic [point_width-1:0] tex0_size_y_i,
    input  logic [point_width-1:0] pixel_x_i,
    input  logic [point_width-1:0] pixel_y_i,
    input  logic [point_width-1:0] pixel_z_i,
    input  logic [point_width-1:0] u_i,
    input  logic [point_width-1:0] v_i,
    input  logic [7:0]             a_i,
    input  logic [31:0]            color_i,
    input  logic                   write_i,
    output logic                   ack_o,
    output logic                   texture_request_o,
    output logic [31:0]            texture_addr_o,
    input  logic [255:0]           texture_data_i,
    input  logic                   texture_ack_i,
    input  logic                   wbm_busy_i,
    output logic [point_width-1:0] pixel_x_o,
    output logic [point_width-1:0] pixel_y_o,
    output logic [point_width-1:0] pixel_z_o,
    output logic [7:0]             a_o,
    output logic [31:0]            color_o,
    output logic                   write_o,
    input  logic                   ack_i
);

    typedef enum logic [1:0] {S_WAIT, S_ADDR, S_FETCH, S_WRITE} state_t;

    state_t                 r_state;
    logic [point_width-1:0] r_x, r_y, r_z, r_u, r_v;
    logic [7:0]             r_a;
    logic [4:0]             r_mb;

    logic [31:0] w_idx, w_off, w_shifted, w_texel;
    logic [15:0] w_alpha_prod;
    logic [7:0]  w_alpha;
    logic        w_depth32;

    assign w_depth32 = color_depth_i[1];
    assign w_idx     = 32'(r_v) * 32'(tex0_size_x_i) + 32'(r_u);

    always_comb begin
        w_off = w_idx;
        case (color_depth_i)
            2'd0:    w_off = w_idx;
            2'd1:    w_off = w_idx << 1;
            default: w_off = w_idx << 2;
        endcase
    end

    // Little-endian line: byte mb lands in bits [7:0] after the shift.
    assign w_shifted = 32'(texture_data_i >> {r_mb, 3'b000});

    always_comb begin
        w_texel = w_shifted;
        case (color_depth_i)
            2'd0:    w_texel = {24'd0, w_shifted[7:0]};
            2'd1:    w_texel = {16'd0, w_shifted[15:0]};
            default: w_texel = w_shifted;
        endcase
    end

    // (a+1)*ta never exceeds 256*255, so 16 bits hold the product.
    assign w_alpha_prod = ({8'd0, r_a} + 16'd1) * {8'd0, w_texel[31:24]};
    assign w_alpha      = 8'(w_alpha_prod >> 8);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state           <= S_WAIT;
            r_x               <= '0;
            r_y               <= '0;
            r_z               <= '0;
            r_u               <= '0;
            r_v               <= '0;
            r_a               <= '0;
            r_mb              <= '0;
            ack_o             <= 1'b0;
            texture_request_o <= 1'b0;
            texture_addr_o    <= '0;
            pixel_x_o         <= '0;
            pixel_y_o         <= '0;
            pixel_z_o         <= '0;
            a_o               <= '0;
            color_o           <= '0;
            write_o           <= 1'b0;
        end else begin
            ack_o   <= 1'b0;
            write_o <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (write_i) begin
                        r_x <= pixel_x_i;
                        r_y <= pixel_y_i;
                        r_z <= pixel_z_i;
                        r_u <= u_i;
                        r_v <= v_i;
                        r_a <= a_i;
                        if (!texture_enable_i) begin
                            pixel_x_o <= pixel_x_i;
                            pixel_y_o <= pixel_y_i;
                            pixel_z_o <= pixel_z_i;
                            color_o   <= color_i;
                            a_o       <= a_i;
                            write_o   <= 1'b1;
                            r_state   <= S_WRITE;
                        end else if (u_i >= tex0_size_x_i || v_i >= tex0_size_y_i) begin
                            ack_o <= 1'b1;
                        end else begin
                            r_state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    texture_addr_o <= tex0_base_i + {w_off[31:5], 5'b00000};
                    r_mb           <= w_off[4:0];
                    // Raising the request here alongside the address saves a cycle when the reader is idle.
                    if (!wbm_busy_i)
                        texture_request_o <= 1'b1;
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (texture_request_o && texture_ack_i) begin
                        texture_request_o <= 1'b0;
                        if (colorkey_enable_i && w_texel == colorkey_i) begin
                            ack_o   <= 1'b1;
                            r_state <= S_WAIT;
                        end else begin
                            pixel_x_o <= r_x;
                            pixel_y_o <= r_y;
                            pixel_z_o <= r_z;
                            color_o   <= w_texel;
                            a_o       <= w_depth32 ? w_alpha : r_a;
                            write_o   <= 1'b1;
                            r_state   <= S_WRITE;
                        end
                    end else if (!wbm_busy_i) begin
                        texture_request_o <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (ack_i) begin
                        ack_o   <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_gfx256_fragment.sv
// Bench for gfx256_fragment: directed table from the test plan, random pixels against
// a byte-addressed memory model, and a reset-during-fetch sequence.
module tb_gfx256_fragment;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          texture_enable_i = 1'b0, colorkey_enable_i = 1'b0;
    logic [31:0]   colorkey_i = '0;
    logic [1:0]    color_depth_i = '0;
    logic [31:0]   tex0_base_i = '0;
    logic [PW-1:0] tex0_size_x_i = '0, tex0_size_y_i = '0;
    logic [PW-1:0] pixel_x_i = '0, pixel_y_i = '0, pixel_z_i = '0, u_i = '0, v_i = '0;
    logic [7:0]    a_i = '0;
    logic [31:0]   color_i = '0;
    logic          write_i = 1'b0;
    logic          ack_o;
    logic          texture_request_o;
    logic [31:0]   texture_addr_o;
    logic [255:0]  texture_data_i = '0;
    logic          texture_ack_i = 1'b0;
    logic          wbm_busy_i = 1'b0;
    logic [PW-1:0] pixel_x_o, pixel_y_o, pixel_z_o;
    logic [7:0]    a_o;
    logic [31:0]   color_o;
    logic          write_o;
    logic          ack_i = 1'b0;

    gfx256_fragment #(.point_width(PW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .texture_enable_i(texture_enable_i), .colorkey_enable_i(colorkey_enable_i),
        .colorkey_i(colorkey_i), .color_depth_i(color_depth_i), .tex0_base_i(tex0_base_i),
        .tex0_size_x_i(tex0_size_x_i), .tex0_size_y_i(tex0_size_y_i),
        .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i),
        .u_i(u_i), .v_i(v_i), .a_i(a_i), .color_i(color_i), .write_i(write_i),
        .ack_o(ack_o), .texture_request_o(texture_request_o), .texture_addr_o(texture_addr_o),
        .texture_data_i(texture_data_i), .texture_ack_i(texture_ack_i), .wbm_busy_i(wbm_busy_i),
        .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .pixel_z_o(pixel_z_o),
        .a_o(a_o), .color_o(color_o), .write_o(write_o), .ack_i(ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          tex, ck_en;
        logic [31:0]   ck;
        logic [1:0]    depth;
        logic [31:0]   base;
        logic [PW-1:0] sx, sy, u, v, x, y, z;
        logic [7:0]    a;
        logic [31:0]   color;
        int            busy;
        logic          inj;
        logic [4:0]    mb;
        logic [31:0]   texel;
        logic          e_write, e_fetch;
        logic [31:0]   e_addr, e_color;
        logic [7:0]    e_a;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   dly = 0;
    vec_t tab[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Texture memory contents as a function of byte address.
    function automatic logic [7:0] mem_byte(input logic [31:0] addr);
        logic [31:0] h;
        h = addr * 32'h9E3779B1;
        return h[31:24] ^ h[7:0];
    endfunction

    function automatic int bpp_of(input logic [1:0] d);
        return (d == 2'd0) ? 1 : (d == 2'd1) ? 2 : 4;
    endfunction

    function automatic vec_t mk(input logic tex, input logic ck_en, input logic [31:0] ck,
                                input logic [1:0] depth, input logic [31:0] base,
                                input logic [PW-1:0] sx, input logic [PW-1:0] sy,
                                input logic [PW-1:0] u, input logic [PW-1:0] v,
                                input logic [7:0] a, input logic [31:0] color, input int busy,
                                input logic inj, input logic [4:0] mb, input logic [31:0] texel,
                                input logic ew, input logic ef, input logic [31:0] eaddr,
                                input logic [31:0] ecol, input logic [7:0] ea);
        vec_t t;
        t.tex = tex; t.ck_en = ck_en; t.ck = ck; t.depth = depth; t.base = base;
        t.sx = sx; t.sy = sy; t.u = u; t.v = v; t.a = a; t.color = color; t.busy = busy;
        t.inj = inj; t.mb = mb; t.texel = texel;
        t.e_write = ew; t.e_fetch = ef; t.e_addr = eaddr; t.e_color = ecol; t.e_a = ea;
        t.x = PW'($urandom); t.y = PW'($urandom); t.z = PW'($urandom);
        return t;
    endfunction

    // Reference: texel is read byte-by-byte from base + idx*bpp in a flat memory.
    function automatic vec_t model(input vec_t t);
        vec_t        r;
        int          bpp;
        logic [31:0] idx, boff, ba, tx;
        r = t;
        r.e_fetch = 1'b0; r.e_addr = '0;
        bpp = bpp_of(t.depth);
        if (!t.tex) begin
            r.e_write = 1'b1; r.e_color = t.color; r.e_a = t.a;
        end else if (t.u >= t.sx || t.v >= t.sy) begin
            r.e_write = 1'b0; r.e_color = '0; r.e_a = '0;
        end else begin
            idx  = 32'(t.v) * 32'(t.sx) + 32'(t.u);
            boff = idx * 32'(bpp);
            ba   = t.base + boff;
            tx   = '0;
            for (int i = 0; i < bpp; i++) tx = tx | (32'(mem_byte(ba + 32'(i))) << (8 * i));
            r.texel   = tx;
            r.e_fetch = 1'b1;
            r.e_addr  = t.base + (boff / 32) * 32;
            r.e_write = !(t.ck_en && tx == t.ck);
            r.e_color = tx;
            r.e_a     = (bpp == 4) ? 8'(((32'(t.a) + 1) * 32'(tx[31:24])) / 256) : t.a;
        end
        return r;
    endfunction

    task automatic apply(input vec_t t);
        texture_enable_i = t.tex; colorkey_enable_i = t.ck_en; colorkey_i = t.ck;
        color_depth_i = t.depth; tex0_base_i = t.base; tex0_size_x_i = t.sx; tex0_size_y_i = t.sy;
        u_i = t.u; v_i = t.v; a_i = t.a; color_i = t.color;
        pixel_x_i = t.x; pixel_y_i = t.y; pixel_z_i = t.z;
    endtask

    task automatic do_pixel(input vec_t t, input string tag);
        int cyc = 1, req_cyc = 0, tack_cyc = 0, wr_cyc = 0, ack_cyc = 0, wr_cnt = 0, bpp, exp_lat;
        logic req_seen = 0, wr_seen = 0, done = 0, addr_bad = 0, req_bad = 0;
        logic [31:0] got_addr = '0, got_color = '0;
        logic [7:0]  got_a = '0;
        logic [PW-1:0] gx = '0, gy = '0, gz = '0;
        logic [255:0] line;
        bpp = bpp_of(t.depth);
        apply(t);
        wbm_busy_i = (t.busy > 0);
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        while (!done && cyc < 200) begin
            if (texture_request_o) begin
                if (!req_seen) begin
                    req_seen = 1; req_cyc = cyc; got_addr = texture_addr_o;
                end else if (texture_addr_o !== got_addr) addr_bad = 1;
                if (tack_cyc > 0) req_bad = 1;
            end
            if (write_o) begin
                if (!wr_seen) begin
                    wr_seen = 1; wr_cyc = cyc; got_color = color_o; got_a = a_o;
                    gx = pixel_x_o; gy = pixel_y_o; gz = pixel_z_o;
                end
                wr_cnt++;
            end
            if (ack_o) begin
                done = 1; ack_cyc = cyc;
            end
            texture_ack_i = 1'b0; ack_i = 1'b0;
            wbm_busy_i = (cyc < t.busy);
            if (req_seen && tack_cyc == 0 && texture_request_o && cyc >= req_cyc + dly) begin
                for (int k = 0; k < 32; k++) line[8*k +: 8] = mem_byte(texture_addr_o + 32'(k));
                if (t.inj)
                    for (int i = 0; i < bpp; i++) line[8*(int'(t.mb) + i) +: 8] = t.texel[8*i +: 8];
                texture_data_i = line; texture_ack_i = 1'b1; tack_cyc = cyc;
            end
            if (wr_seen && cyc == wr_cyc + 3) ack_i = 1'b1;
            tick();
            cyc++;
        end
        texture_ack_i = 1'b0; ack_i = 1'b0; wbm_busy_i = 1'b0;
        if (!done) begin
            chk({tag, " timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, " ack_pulse"}, 32'(ack_o), 32'd0);
        chk({tag, " fetch"}, 32'(req_seen), 32'(t.e_fetch));
        if (t.e_fetch && req_seen) begin
            chk({tag, " addr"}, got_addr, t.e_addr);
            exp_lat = (t.busy + 1 > 2) ? t.busy + 1 : 2;
            chk({tag, " req_lat"}, 32'(req_cyc), 32'(exp_lat));
            chk({tag, " addr_stable"}, 32'(addr_bad), 32'd0);
            chk({tag, " req_drop"}, 32'(req_bad), 32'd0);
        end
        chk({tag, " write"}, 32'(wr_seen), 32'(t.e_write));
        if (t.e_write && wr_seen) begin
            chk({tag, " color"}, got_color, t.e_color);
            chk({tag, " alpha"}, 32'(got_a), 32'(t.e_a));
            chk({tag, " xyz"}, {gx, gy}, {t.x, t.y});
            chk({tag, " z"}, 32'(gz), 32'(t.z));
            chk({tag, " wr_pulse"}, 32'(wr_cnt), 32'd1);
            chk({tag, " wr_lat"}, 32'(wr_cyc), t.tex ? 32'(tack_cyc + 1) : 32'd1);
            chk({tag, " ack_lat"}, 32'(ack_cyc), 32'(wr_cyc + 4));
        end else if (!t.e_write) begin
            chk({tag, " disc_lat"}, 32'(ack_cyc), t.e_fetch ? 32'(tack_cyc + 1) : 32'd1);
        end
    endtask

    initial begin
        vec_t t;
        int   n;
        //          tex ck  ckval        dep  base          sx  sy  u   v   a      color        busy inj mb     texel        ew ef eaddr         ecolor       ea
        tab[0] = mk(0, 0, 32'h0,       2'd0, 32'h0,        16, 16, 0,  0,  8'h80, 32'h11223344, 0, 0, 5'd0,  32'h0,       1, 0, 32'h0,        32'h11223344, 8'h80);
        tab[1] = mk(1, 0, 32'h0,       2'd2, 32'h10000000, 64, 64, 3,  2,  8'hFF, 32'h0,        0, 1, 5'd12, 32'h80AABBCC, 1, 1, 32'h10000200, 32'h80AABBCC, 8'h80);
        tab[2] = mk(1, 0, 32'h0,       2'd0, 32'h20000000, 32, 32, 5,  1,  8'h33, 32'h0,        4, 1, 5'd5,  32'h7E,       1, 1, 32'h20000020, 32'h0000007E, 8'h33);
        tab[3] = mk(1, 1, 32'hF81F,    2'd1, 32'h30000000, 16, 16, 2,  3,  8'h44, 32'h0,        0, 1, 5'd4,  32'hF81F,     0, 1, 32'h30000060, 32'h0,        8'h00);
        tab[4] = mk(1, 0, 32'h0,       2'd2, 32'h0,        16, 16, 16, 0,  8'h10, 32'h0,        0, 0, 5'd0,  32'h0,       0, 0, 32'h0,        32'h0,        8'h00);
        tab[5] = mk(1, 0, 32'h0,       2'd2, 32'h0,        16, 16, 0,  16, 8'h10, 32'h0,        0, 0, 5'd0,  32'h0,       0, 0, 32'h0,        32'h0,        8'h00);
        tab[6] = mk(1, 0, 32'h0,       2'd2, 32'h0,        16, 16, 1,  0,  8'h00, 32'h0,        0, 1, 5'd4,  32'hFF123456, 1, 1, 32'h0,        32'hFF123456, 8'h00);
        tab[7] = mk(1, 1, 32'h12345679, 2'd2, 32'h0,       16, 16, 2,  0,  8'h7F, 32'h0,        1, 1, 5'd8,  32'h12345678, 1, 1, 32'h0,        32'h12345678, 8'h09);
        tab[8] = mk(1, 0, 32'h0,       2'd3, 32'h10,       8,  8,  7,  7,  8'hFF, 32'h0,        0, 1, 5'd28, 32'h40000001, 1, 1, 32'hF0,       32'h40000001, 8'h40);
        tab[9] = mk(1, 0, 32'h0,       2'd0, 32'h0,        16, 16, 15, 15, 8'h11, 32'h0,        2, 1, 5'd31, 32'h9C,       1, 1, 32'hE0,       32'h0000009C, 8'h11);

        rst_i = 1'b1;
        tick(); tick();
        chk("rst write_o", 32'(write_o), 32'd0);
        chk("rst ack_o", 32'(ack_o), 32'd0);
        chk("rst request", 32'(texture_request_o), 32'd0);
        chk("rst addr", texture_addr_o, 32'd0);
        chk("rst color", color_o, 32'd0);
        chk("rst a_xy", {a_o, 8'd0, pixel_x_o}, 32'd0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            dly = i % 3;
            do_pixel(tab[i], $sformatf("vec%0d", i));
            tick();
        end

        // Reset while the fetch request is outstanding: request falls, no ack.
        apply(tab[1]);
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        n = 0;
        while (!texture_request_o && n < 10) begin
            tick();
            n++;
        end
        chk("rstfetch req_up", 32'(texture_request_o), 32'd1);
        rst_i = 1'b1;
        tick();
        chk("rstfetch req_down", 32'(texture_request_o), 32'd0);
        chk("rstfetch no_ack", {31'd0, ack_o | write_o}, 32'd0);
        rst_i = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ack_o || write_o || texture_request_o) n++;
        end
        chk("rstfetch idle", 32'(n), 32'd0);
        dly = 1;
        do_pixel(tab[1], "after_rst");
        tick();

        for (int i = 0; i < 60; i++) begin
            t = mk(1'($urandom), 1'($urandom), $urandom, 2'($urandom), $urandom,
                   PW'($urandom_range(1, 64)), PW'($urandom_range(1, 64)), 0, 0,
                   8'($urandom), $urandom, int'($urandom_range(0, 3)), 0, 5'd0, 32'h0,
                   0, 0, 32'h0, 32'h0, 8'h0);
            t.u = PW'($urandom_range(0, int'(t.sx)));
            t.v = PW'($urandom_range(0, int'(t.sy)));
            t = model(t);
            if (t.ck_en && t.e_fetch && $urandom_range(0, 1) == 1) begin
                t.ck = t.texel;
                t = model(t);
            end
            dly = int'($urandom_range(0, 3));
            do_pixel(t, $sformatf("rnd%0d", i));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
